// File: rtl/cfu_pkg.sv
// ----------------------------------------------------------------------------
// cfu_pkg
// Shared control-flow-unit types and helpers.
//   cfuop_t     : resolved control-flow operation from execute (BEQ..JALR, NB)
//   btb_etype_t : kind of instruction held by a BTB entry
//   is_cond_f   : true for the conditional-branch ops BEQ..BGEU
//   ctr_sat_f   : saturating up/down step of a direction counter
// ----------------------------------------------------------------------------
package cfu_pkg;

   typedef enum logic [3:0] {
      BEQ  = 4'd0,
      BNE  = 4'd1,
      BLT  = 4'd2,
      BGE  = 4'd3,
      BLTU = 4'd4,
      BGEU = 4'd5,
      JAL  = 4'd6,
      JALR = 4'd7,
      NB   = 4'd8
   } cfuop_t;

   typedef enum logic [1:0] {
      COND = 2'd0,
      JUMP = 2'd1,
      RET  = 2'd2
   } btb_etype_t;

   // Widest direction counter the helper handles; callers zero-extend into it.
   localparam int unsigned CTR_MAX_W = 8;

   function automatic logic is_cond_f(input cfuop_t op);
      logic res;
      case (op)
         BEQ, BNE, BLT, BGE, BLTU, BGEU: res = 1'b1;
         default:                        res = 1'b0;
      endcase
      return res;
   endfunction

   // ctr_max is the all-ones value of the caller's counter width.
   function automatic logic [CTR_MAX_W-1:0] ctr_sat_f(
      input logic [CTR_MAX_W-1:0] ctr,
      input logic                 taken,
      input logic [CTR_MAX_W-1:0] ctr_max
   );
      logic [CTR_MAX_W-1:0] res;
      if (taken) begin
         if (ctr >= ctr_max) begin
            res = ctr_max;
         end else begin
            res = ctr + 8'd1;
         end
      end else begin
         if (ctr == 8'd0) begin
            res = 8'd0;
         end else begin
            res = ctr - 8'd1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bpu_ras.sv
// ----------------------------------------------------------------------------
// bpu_ras
// Circular return-address stack trained from the resolved instruction stream.
// A push when full overwrites the oldest entry; a pop when empty is ignored.
// With pop and push together the pop is applied first.
// Ports:
//   clk, arst_n   clock / asynchronous active-low reset (stack emptied)
//   push_i        push push_addr_i
//   pop_i         pop the top entry
//   push_addr_i   return address to push
//   valid_o       stack is non-empty
//   top_o         current top of stack (meaningful when valid_o)
// ----------------------------------------------------------------------------
module bpu_ras #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] push_addr_i,
   output logic            valid_o,
   output logic [XLEN-1:0] top_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [XLEN-1:0]  stack_q [DEPTH];
   logic [PTR_W-1:0] sp_q, sp_d;       // next free slot; top is sp_q - 1
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_en_d;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] pop_sp_s;
   logic [CNT_W-1:0] pop_cnt_s;

   function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_LAST) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec_f(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == '0) begin
         r = PTR_LAST;
      end else begin
         r = p - PTR_W'(1);
      end
      return r;
   endfunction

   // Next pointer/count: apply a (non-empty) pop first, then any push.
   always_comb begin
      pop_sp_s  = sp_q;
      pop_cnt_s = cnt_q;
      sp_d      = sp_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_ptr_d  = sp_q;
      if (pop_i && (cnt_q != '0)) begin
         pop_sp_s  = ptr_dec_f(sp_q);
         pop_cnt_s = cnt_q - CNT_W'(1);
      end else begin
         pop_sp_s  = sp_q;
         pop_cnt_s = cnt_q;
      end
      if (push_i) begin
         wr_en_d  = 1'b1;
         wr_ptr_d = pop_sp_s;
         sp_d     = ptr_inc_f(pop_sp_s);
         // Full stack: the push recycles the oldest slot, depth stays saturated.
         if (pop_cnt_s == CNT_FULL) begin
            cnt_d = pop_cnt_s;
         end else begin
            cnt_d = pop_cnt_s + CNT_W'(1);
         end
      end else begin
         sp_d  = pop_sp_s;
         cnt_d = pop_cnt_s;
      end
   end

   // Stack pointer and occupancy registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
      end
   end

   // Stack storage.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stack_q[i] <= '0;
         end
      end else if (wr_en_d) begin
         stack_q[wr_ptr_d] <= push_addr_i;
      end
   end

   assign valid_o = (cnt_q != '0);
   assign top_o   = stack_q[ptr_dec_f(sp_q)];

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with CTR_W-bit saturating direction
// counters. A lookup with the fetch PC yields registered taken/target one
// cycle later; execute trains the table with the resolved cfuop_t.
// Optional feature macro: BPU_RAS_EN adds a RAS_DEPTH return-address stack
// (bpu_ras) whose top overrides the stored target of RET entries.
// Ports:
//   clk, arst_n                 clock / asynchronous active-low reset
//   lkp_valid_i, lkp_pc_i       lookup request and fetch PC
//   pred_valid_o                lookup was issued the previous cycle
//   pred_taken_o, pred_target_o prediction (held while no lookup issued)
//   upd_valid_i, upd_pc_i       resolved control-flow instruction and its PC
//   upd_cfuop_i                 resolved op; NB means no update
//   upd_taken_i, upd_target_i   actual outcome and target
//   upd_call_i, upd_ret_i       call / return classification
// ----------------------------------------------------------------------------
module branch_predictor
   import cfu_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_ENTRIES = 64,
   parameter int unsigned CTR_W       = 2,
   parameter int unsigned RAS_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            lkp_valid_i,
   input  logic [XLEN-1:0] lkp_pc_i,
   output logic            pred_valid_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  cfuop_t          upd_cfuop_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            upd_call_i,
   input  logic            upd_ret_i
);

   localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

   // BTB storage
   logic             valid_q      [NUM_ENTRIES];
   logic [TAG_W-1:0] tag_q        [NUM_ENTRIES];
   logic [XLEN-1:0]  btb_target_q [NUM_ENTRIES];
   logic [CTR_W-1:0] ctr_q        [NUM_ENTRIES];
   btb_etype_t       etype_q      [NUM_ENTRIES];

   // Lookup path
   logic [IDX_W-1:0] lkp_idx_s;
   logic [TAG_W-1:0] lkp_tag_s;
   logic             lkp_hit_s;
   logic             pred_taken_d;
   logic [XLEN-1:0]  pred_target_d;
   logic             pred_valid_q;
   logic             pred_taken_q;
   logic [XLEN-1:0]  pred_target_q;

   // Update path
   logic [IDX_W-1:0] upd_idx_s;
   logic [TAG_W-1:0] upd_tag_s;
   logic             upd_hit_s;
   logic             upd_en_s;
   logic             wr_en_d;
   logic [CTR_W-1:0] wr_ctr_d;
   logic [XLEN-1:0]  wr_target_d;
   btb_etype_t       wr_etype_d;

   logic             ras_valid_s;
   logic [XLEN-1:0]  ras_top_s;
   logic             unused_s;

   assign lkp_idx_s = lkp_pc_i[IDX_W+1:2];
   assign lkp_tag_s = lkp_pc_i[XLEN-1:IDX_W+2];
   assign lkp_hit_s = valid_q[lkp_idx_s] && (tag_q[lkp_idx_s] == lkp_tag_s);

   assign upd_idx_s = upd_pc_i[IDX_W+1:2];
   assign upd_tag_s = upd_pc_i[XLEN-1:IDX_W+2];
   assign upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
   assign upd_en_s  = upd_valid_i && (upd_cfuop_i != NB);

`ifdef BPU_RAS_EN
   logic ras_push_s;
   logic ras_pop_s;

   assign ras_push_s = upd_en_s && upd_call_i;
   assign ras_pop_s  = upd_en_s && upd_ret_i;

   bpu_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .arst_n      (arst_n),
      .push_i      (ras_push_s),
      .pop_i       (ras_pop_s),
      .push_addr_i (upd_pc_i + XLEN'(32'd4)),
      .valid_o     (ras_valid_s),
      .top_o       (ras_top_s)
   );

   assign unused_s = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};
`else
   assign ras_valid_s = 1'b0;
   assign ras_top_s   = '0;
   assign unused_s    = ^{lkp_pc_i[1:0], upd_pc_i[1:0], upd_call_i, ras_valid_s, ras_top_s};
`endif

   // Prediction for the current lookup, formed from pre-update table state.
   always_comb begin
      pred_taken_d  = 1'b0;
      pred_target_d = lkp_pc_i + XLEN'(32'd4);
      if (lkp_hit_s) begin
         case (etype_q[lkp_idx_s])
            COND: begin
               pred_taken_d  = ctr_q[lkp_idx_s][CTR_W-1];
               pred_target_d = btb_target_q[lkp_idx_s];
            end
            JUMP: begin
               pred_taken_d  = 1'b1;
               pred_target_d = btb_target_q[lkp_idx_s];
            end
            RET: begin
               pred_taken_d = 1'b1;
`ifdef BPU_RAS_EN
               // An empty stack falls back to the target learnt at training.
               if (ras_valid_s) begin
                  pred_target_d = ras_top_s;
               end else begin
                  pred_target_d = btb_target_q[lkp_idx_s];
               end
`else
               pred_target_d = btb_target_q[lkp_idx_s];
`endif
            end
            default: begin
               pred_taken_d  = 1'b0;
               pred_target_d = lkp_pc_i + XLEN'(32'd4);
            end
         endcase
      end else begin
         pred_taken_d  = 1'b0;
         pred_target_d = lkp_pc_i + XLEN'(32'd4);
      end
   end

   // Registered prediction outputs; taken/target hold when no lookup issued.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         pred_valid_q <= lkp_valid_i;
         if (lkp_valid_i) begin
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
         end
      end
   end

   // Entry write decision for the resolved instruction.
   always_comb begin
      wr_en_d     = 1'b0;
      wr_ctr_d    = ctr_q[upd_idx_s];
      wr_target_d = btb_target_q[upd_idx_s];
      wr_etype_d  = etype_q[upd_idx_s];
      if (upd_en_s) begin
         if (is_cond_f(upd_cfuop_i)) begin
            if (upd_hit_s) begin
               wr_en_d  = 1'b1;
               wr_ctr_d = CTR_W'(ctr_sat_f(CTR_MAX_W'(ctr_q[upd_idx_s]), upd_taken_i,
                                           CTR_MAX_W'(CTR_MAX)));
               if (upd_taken_i) begin
                  wr_target_d = upd_target_i;
               end else begin
                  wr_target_d = btb_target_q[upd_idx_s];
               end
            end else if (upd_taken_i) begin
               // Taken miss allocates over whatever occupied the slot.
               wr_en_d     = 1'b1;
               wr_ctr_d    = CTR_WT;
               wr_target_d = upd_target_i;
               wr_etype_d  = COND;
            end else begin
               // Not-taken miss leaves the table untouched.
               wr_en_d = 1'b0;
            end
         end else begin
            wr_en_d     = 1'b1;
            wr_ctr_d    = CTR_MAX;
            wr_target_d = upd_target_i;
            if (upd_ret_i) begin
               wr_etype_d = RET;
            end else begin
               wr_etype_d = JUMP;
            end
         end
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // BTB table: cleared on reset, one entry written per update.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            valid_q[i]      <= 1'b0;
            tag_q[i]        <= '0;
            btb_target_q[i] <= '0;
            ctr_q[i]        <= CTR_WNT;
            etype_q[i]      <= COND;
         end
      end else if (wr_en_d) begin
         valid_q[upd_idx_s]      <= 1'b1;
         tag_q[upd_idx_s]        <= upd_tag_s;
         btb_target_q[upd_idx_s] <= wr_target_d;
         ctr_q[upd_idx_s]        <= wr_ctr_d;
         etype_q[upd_idx_s]      <= wr_etype_d;
      end
   end

   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;
   assign pred_target_o = pred_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
// Directed and randomized checks of branch_predictor (default parameters)
// against a behavioural model of the BTB kept as per-slot records with full
// PCs, integer counters and, with BPU_RAS_EN, a queue for the return stack.
// ----------------------------------------------------------------------------
module tb_branch_predictor;
   import cfu_pkg::*;

   localparam int IDX_W   = 6;
   localparam int ENTRIES = 64;
   localparam int CMAX    = 3;   // 2-bit counter
   localparam int RASD    = 4;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        lkp_valid_i = 1'b0;
   logic [31:0] lkp_pc_i = '0;
   logic        pred_valid_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i = 1'b0;
   logic [31:0] upd_pc_i = '0;
   cfuop_t      upd_cfuop_i = NB;
   logic        upd_taken_i = 1'b0;
   logic [31:0] upd_target_i = '0;
   logic        upd_call_i = 1'b0;
   logic        upd_ret_i = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   bit          m_valid [ENTRIES];
   logic [31:0] m_pc    [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   int          m_kind  [ENTRIES];   // 0 conditional, 1 jump, 2 return
   logic [31:0] m_ras   [$];
   bit          e_valid;
   bit          e_taken;
   logic [31:0] e_target;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .lkp_valid_i   (lkp_valid_i),
      .lkp_pc_i      (lkp_pc_i),
      .pred_valid_o  (pred_valid_o),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_cfuop_i   (upd_cfuop_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i),
      .upd_call_i    (upd_call_i),
      .upd_ret_i     (upd_ret_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      int s = slot(pc);
      return m_valid[s] && ((m_pc[s] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1; m_kind[i] = 0;
      end
      m_ras.delete();
      e_valid = 1'b0; e_taken = 1'b0; e_target = '0;
   endtask

   task automatic m_predict(input logic [31:0] pc);
      int s = slot(pc);
      if (!m_hit(pc)) begin
         e_taken = 1'b0; e_target = pc + 32'd4;
      end else if (m_kind[s] == 0) begin
         e_taken = (m_ctr[s] >= 2); e_target = m_tgt[s];
      end else begin
         e_taken = 1'b1; e_target = m_tgt[s];
`ifdef BPU_RAS_EN
         if (m_kind[s] == 2 && m_ras.size() > 0) e_target = m_ras[$];
`endif
      end
   endtask

   task automatic m_update(input bit uv, input cfuop_t op, input logic [31:0] pc, input bit tk,
                           input logic [31:0] tgt, input bit call, input bit ret);
      int s = slot(pc);
      bit branch = (op == BEQ) || (op == BNE) || (op == BLT) || (op == BGE) ||
                   (op == BLTU) || (op == BGEU);
      if (!uv || op == NB) return;
      if (branch) begin
         if (m_hit(pc)) begin
            m_ctr[s] = tk ? ((m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1)
                          : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
            if (tk) m_tgt[s] = tgt;
         end else if (tk) begin
            m_valid[s] = 1'b1; m_pc[s] = pc; m_ctr[s] = 2; m_tgt[s] = tgt; m_kind[s] = 0;
         end
      end else begin
         m_valid[s] = 1'b1; m_pc[s] = pc; m_ctr[s] = CMAX; m_tgt[s] = tgt;
         m_kind[s] = ret ? 2 : 1;
      end
`ifdef BPU_RAS_EN
      if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
      if (call) begin
         m_ras.push_back(pc + 32'd4);
         if (m_ras.size() > RASD) void'(m_ras.pop_front());
      end
`endif
   endtask

   // One clock of stimulus, followed by a check of the registered outputs.
   task automatic step(input bit lv, input logic [31:0] lpc, input bit uv, input cfuop_t op,
                       input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                       input bit call, input bit ret, input string tag);
      @(negedge clk);
      lkp_valid_i = lv; lkp_pc_i = lpc;
      upd_valid_i = uv; upd_cfuop_i = op; upd_pc_i = upc; upd_taken_i = tk;
      upd_target_i = tgt; upd_call_i = call; upd_ret_i = ret;
      e_valid = lv;
      if (lv) m_predict(lpc);
      m_update(uv, op, upc, tk, tgt, call, ret);
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, {31'd0, pred_valid_o}, {31'd0, e_valid});
      chk({tag, ".taken"}, {31'd0, pred_taken_o}, {31'd0, e_taken});
      chk({tag, ".target"}, pred_target_o, e_target);
   endtask

   task automatic lookup(input logic [31:0] pc, input string tag);
      step(1'b1, pc, 1'b0, NB, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, tag);
   endtask

   task automatic train(input cfuop_t op, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit call, input bit ret, input string tag);
      step(1'b0, 32'd0, 1'b1, op, pc, tk, tgt, call, ret, tag);
   endtask

   initial begin
      logic [31:0] rpc;
      logic [31:0] upc;
      cfuop_t      rop;
      m_reset();
      #12;
      chk("reset.valid", {31'd0, pred_valid_o}, 32'd0);
      chk("reset.taken", {31'd0, pred_taken_o}, 32'd0);
      chk("reset.target", pred_target_o, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;

      // cold miss
      lookup(32'h100, "miss100");
      chk("miss100.lit", pred_target_o, 32'h104);
      // idle cycle: valid drops, taken/target hold
      step(1'b0, 32'h0, 1'b0, NB, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "hold");

      // BEQ allocation and decay to not-taken
      train(BEQ, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, "beq_t");
      lookup(32'h100, "beq_hit");
      chk("beq_hit.lit", pred_target_o, 32'h80);
      train(BEQ, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, "beq_nt1");
      train(BEQ, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, "beq_nt2");
      lookup(32'h100, "beq_decay");
      chk("beq_decay.lit", {31'd0, pred_taken_o}, 32'd0);

      // saturation: five taken then one not-taken stays taken
      for (int i = 0; i < 5; i++) train(BNE, 32'h180, 1'b1, 32'h40, 1'b0, 1'b0, "sat_t");
      train(BNE, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0, "sat_nt");
      lookup(32'h180, "sat");
      chk("sat.lit", {31'd0, pred_taken_o}, 32'd1);

      // NB and upd_valid low leave the table unchanged; not-taken miss no alloc
      train(NB, 32'h1c0, 1'b1, 32'h44, 1'b0, 1'b0, "nb");
      step(1'b0, 32'h0, 1'b0, JAL, 32'h1c0, 1'b1, 32'h44, 1'b0, 1'b0, "uv0");
      train(BLT, 32'h1c0, 1'b0, 32'h44, 1'b0, 1'b0, "nt_miss");
      lookup(32'h1c0, "noalloc");

      // aliasing JALs on the same index
      train(JAL, 32'h100, 1'b1, 32'h500, 1'b0, 1'b0, "jal100");
      train(JAL, 32'h200, 1'b1, 32'h600, 1'b0, 1'b0, "jal200");
      lookup(32'h100, "alias100");
      chk("alias100.lit", pred_target_o, 32'h104);
      lookup(32'h200, "alias200");
      chk("alias200.lit", pred_target_o, 32'h600);

      // same-cycle lookup and update: old state seen, update commits
      step(1'b1, 32'h300, 1'b1, JALR, 32'h300, 1'b1, 32'h700, 1'b0, 1'b0, "same");
      chk("same.lit", pred_target_o, 32'h304);
      lookup(32'h300, "same_after");
      chk("same_after.lit", pred_target_o, 32'h700);

      // reset mid-operation with a lookup pending
      @(negedge clk);
      lkp_valid_i = 1'b1; lkp_pc_i = 32'h200; upd_valid_i = 1'b0;
      #2 arst_n = 1'b0;
      m_reset();
      #1;
      chk("midrst.target", pred_target_o, 32'd0);
      @(posedge clk);
      #1;
      chk("midrst.valid", {31'd0, pred_valid_o}, 32'd0);
      @(negedge clk);
      lkp_valid_i = 1'b0;
      arst_n = 1'b1;
      lookup(32'h200, "post_rst");

`ifdef BPU_RAS_EN
      train(JAL, 32'h1000, 1'b1, 32'h5000, 1'b1, 1'b0, "call1");
      train(JAL, 32'h1000, 1'b1, 32'h5000, 1'b1, 1'b0, "call2");
      train(JALR, 32'h2000, 1'b1, 32'h0, 1'b0, 1'b1, "ret");
      lookup(32'h2000, "ras_top");
      chk("ras_top.lit", pred_target_o, 32'h1004);
      for (int k = 0; k < 5; k++)
         train(JAL, 32'h3004 + 32'(k * 8), 1'b1, 32'h6000, 1'b1, 1'b0, "push");
      for (int k = 0; k < 5; k++)
         step(1'b1, 32'h2000, 1'b1, JALR, 32'h2000, 1'b1, 32'h0, 1'b0, 1'b1, "pop");
      lookup(32'h2000, "ras_empty");
      chk("ras_empty.lit", pred_target_o, 32'h0);
`endif

      // randomized traffic over a small aliasing PC pool
      for (int n = 0; n < 400; n++) begin
         rpc = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 3)) << 8);
         upc = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 3)) << 8);
         rop = cfuop_t'(4'($urandom_range(0, 8)));
         step(1'($urandom_range(0, 3) != 0), rpc, 1'($urandom_range(0, 1)), rop, upc,
              1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
